// File: rtl/run_sequencer_pkg.sv
// Shared types and widths for the run sequencer: FSM states and field widths.
package run_sequencer_pkg;
    localparam int DLY_W  = 16;
    localparam int NP_W   = 8;
    localparam int CNT_W  = 32;
    localparam int DROP_W = 16;
    // One extra bit so a zero-pulse run can hold DELAY for delay_cycles+1.
    localparam int DCNT_W = DLY_W + 1;

    typedef enum logic [2:0] {IDLE, DELAY, PULSE, GAP, DONE} seq_state_t;
endpackage

// File: rtl/run_sequencer_if.sv
// Control/status bundle between the run sequencer and its controller.
interface run_sequencer_if;
    import run_sequencer_pkg::*;

    logic              in_start;
    logic              enable;
    logic [DLY_W-1:0]  delay_cycles;
    logic [NP_W-1:0]   num_pulses;
    logic [DLY_W-1:0]  pulse_gap;
    logic              clr_err;
    logic              pulse_out;
    logic              busy;
    logic              done;
    logic [CNT_W-1:0]  start_count;
    logic [DROP_W-1:0] drop_count;
    logic              overlap_err;

    modport master (
        output in_start, enable, delay_cycles, num_pulses, pulse_gap, clr_err,
        input  pulse_out, busy, done, start_count, drop_count, overlap_err
    );
    modport slave (
        input  in_start, enable, delay_cycles, num_pulses, pulse_gap, clr_err,
        output pulse_out, busy, done, start_count, drop_count, overlap_err
    );
endinterface

// File: rtl/run_sequencer_seq_down_counter.sv
// Loadable down-counter with zero flag; times both DELAY and GAP intervals.
module seq_down_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);
    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (load)
            cnt <= load_val;
        else if (dec && cnt != '0)
            cnt <= cnt - W'(1);
    end

    assign zero = (cnt == '0);
endmodule

// File: rtl/run_sequencer.sv
// Start-triggered pulse sequencer: delay, N one-cycle pulses spaced by a gap, then done.
module run_sequencer
    import run_sequencer_pkg::*;
(
    input logic          clk,
    input logic          rst_n,
    run_sequencer_if.slave bus
);
    seq_state_t        state;
    logic [NP_W-1:0]   num_q;
    logic [NP_W-1:0]   idx;
    logic [DLY_W-1:0]  gap_q;
    logic              accept, drop;
    logic              cnt_load, cnt_dec, cnt_zero;
    logic [DCNT_W-1:0] cnt_val;

    assign accept   = (state == IDLE) && bus.in_start && bus.enable;
    assign drop     = (state != IDLE) && bus.in_start && bus.enable;
    assign cnt_load = accept || (state == PULSE && bus.enable && idx != num_q);
    assign cnt_dec  = bus.enable && (state == DELAY || state == GAP);
    assign bus.busy = (state != IDLE);

    // GAP is entered one cycle after PULSE, hence gap-1; DELAY exits on zero,
    // so a zero-pulse run gets one extra cycle in place of the first pulse slot.
    always_comb begin
        cnt_val = DCNT_W'(gap_q) - DCNT_W'(1);
        if (accept)
            cnt_val = DCNT_W'(bus.delay_cycles) + DCNT_W'(bus.num_pulses == '0);
    end

    seq_down_counter #(.W(DCNT_W)) u_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (cnt_load),
        .load_val (cnt_val),
        .dec      (cnt_dec),
        .zero     (cnt_zero)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            num_q         <= '0;
            gap_q         <= '0;
            idx           <= '0;
            bus.pulse_out <= 1'b0;
            bus.done      <= 1'b0;
        end else begin
            bus.pulse_out <= 1'b0;
            bus.done      <= 1'b0;
            if (state == IDLE) begin
                if (accept) begin
                    num_q <= bus.num_pulses;
                    gap_q <= (bus.pulse_gap == '0) ? DLY_W'(1) : bus.pulse_gap;
                    idx   <= '0;
                    state <= DELAY;
                end
            end else if (!bus.enable) begin
                state <= IDLE;
            end else begin
                case (state)
                    DELAY: if (cnt_zero) begin
                        if (num_q == '0) begin
                            state    <= DONE;
                            bus.done <= 1'b1;
                        end else begin
                            state         <= PULSE;
                            bus.pulse_out <= 1'b1;
                            idx           <= idx + NP_W'(1);
                        end
                    end
                    PULSE: if (idx == num_q) begin
                        state    <= DONE;
                        bus.done <= 1'b1;
                    end else begin
                        state <= GAP;
                    end
                    GAP: if (cnt_zero) begin
                        state         <= PULSE;
                        bus.pulse_out <= 1'b1;
                        idx           <= idx + NP_W'(1);
                    end
                    DONE:    state <= IDLE;
                    default: state <= IDLE;
                endcase
            end
        end
    end

    // A drop in the same cycle as clr_err wins: the error survives the clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.start_count <= '0;
            bus.drop_count  <= '0;
            bus.overlap_err <= 1'b0;
        end else begin
            if (accept)
                bus.start_count <= bus.start_count + CNT_W'(1);
            if (drop) begin
                bus.overlap_err <= 1'b1;
                if (bus.clr_err)
                    bus.drop_count <= DROP_W'(1);
                else if (bus.drop_count != '1)
                    bus.drop_count <= bus.drop_count + DROP_W'(1);
            end else if (bus.clr_err) begin
                bus.overlap_err <= 1'b0;
                bus.drop_count  <= '0;
            end
        end
    end
endmodule
